// File: rtl/clk_period_meter_pkg.sv
// Shared timing definitions for the slow-clock meter and the toggle divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// DEF_EXP_PERIOD is the one place the divider period lives. The divider and
// the meter both take their default from it, so the two cannot drift apart.
package clk_period_meter_pkg;

  // Measurement FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meter_state_e;

  localparam int DEF_CNT_W      = 32;
  localparam int DEF_EXP_PERIOD = 100;

endpackage

// File: rtl/clk_period_meter_if.sv
// Bundle of the meter's control input, the slow input and the measurement outputs.
// Latency: n/a (wiring only).
// Backpressure: none; every output is a level or a one-cycle pulse that the consumer samples each cycle.
//
// Ports (master = meter side):
//   en, sig_in                  -> into the meter
//   tick, period, high_time,
//   period_valid, locked,
//   timeout                     <- from the meter
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             en;
  logic             sig_in;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  modport master (
    input  en, sig_in,
    output tick, period, high_time, period_valid, locked, timeout
  );

  modport slave (
    output en, sig_in,
    input  tick, period, high_time, period_valid, locked, timeout
  );
endinterface

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Two-flop synchroniser plus a history flop, giving a clean level and single-cycle rise/fall strobes.
// Latency: level is 2 clk edges after d_i is sampled; rise/fall are combinational off level and history.
// Backpressure: none.
//
// Ports: clk, rst (async, active-low), d_i (asynchronous input),
//        level_o (synchronised level), rise_o, fall_o (one-cycle strobes).
module clk_period_meter_sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and high time of a slow square wave, emits a tick per rise, flags lock and loss of input.
// Latency: tick/period/period_valid appear 3 clk edges after sig_in is first sampled high (2 sync + 1 output register).
// Backpressure: none; tick and period_valid are one-cycle pulses that the consumer must take when they occur.
//
// Ports: clk, rst (async, active-low) plain; bus (clk_period_meter_if.master):
//   en in, sig_in in (async), tick out, period out, high_time out,
//   period_valid out, locked out, timeout out (sticky).
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = 2,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 1000000
) (
  input logic                clk,
  input logic                rst,
  clk_period_meter_if.master bus
);

  localparam int LC_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [LC_W-1:0]  LN_C  = LC_W'(LOCK_N);

  logic level;
  logic rise;
  logic fall;

  clk_period_meter_sync_edge_detect u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (bus.sig_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  meter_state_e     state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] hcnt_q,     hcnt_d;
  logic [CNT_W-1:0] period_q,   period_d;
  logic [CNT_W-1:0] high_q,     high_d;
  logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic             tick_q,     tick_d;
  logic             pv_q,       pv_d;
  logic             locked_q,   locked_d;
  logic             tmo_q,      tmo_d;

  // Both counters saturate at TIMEOUT so a dead input can never wrap them
  // back into a plausible-looking period.
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hcnt_inc;
  logic [CNT_W-1:0] diff;
  logic             in_range;
  logic [LC_W-1:0]  lock_inc;

  assign cnt_inc  = (cnt_q  < TO_C) ? cnt_q  + ONE_C : TO_C;
  assign hcnt_inc = (hcnt_q < TO_C) ? hcnt_q + ONE_C : TO_C;

  // Absolute difference taken by ordering first, so no signed arithmetic
  // or underflow is involved.
  assign diff     = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
  assign in_range = (diff <= TOL_C);
  assign lock_inc = (lock_cnt_q == LN_C) ? LN_C : lock_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    period_d   = period_q;
    high_d     = high_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    tmo_d      = tmo_q;
    pv_d       = 1'b0;
    tick_d     = rise & bus.en;

    if (!bus.en) begin
      // Disable overrides everything, including a rise in the same cycle.
      // period/high_time keep their last values for the consumer.
      state_d    = ST_IDLE;
      cnt_d      = '0;
      hcnt_d     = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      tmo_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
        end

        ST_ARM: begin
          if (rise) begin
            // First edge only opens the window; there is nothing to report yet.
            cnt_d   = ONE_C;
            hcnt_d  = ONE_C;
            tmo_d   = 1'b0;
            state_d = ST_MEAS;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_q == TO_C) begin
              tmo_d      = 1'b1;
              locked_d   = 1'b0;
              lock_cnt_d = '0;
            end
          end
        end

        ST_MEAS: begin
          if (rise) begin
            // A rise on the timeout cycle is still a valid period.
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = ONE_C;
            hcnt_d   = ONE_C;
            tmo_d    = 1'b0;
            if (in_range) begin
              lock_cnt_d = lock_inc;
              locked_d   = (lock_inc == LN_C);
            end else begin
              lock_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc;
            if (fall) begin
              high_d = hcnt_q;
            end else if (level) begin
              hcnt_d = hcnt_inc;
            end
            if (cnt_q == TO_C) begin
              tmo_d      = 1'b1;
              locked_d   = 1'b0;
              lock_cnt_d = '0;
              state_d    = ST_ARM;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      lock_cnt_q <= '0;
      tick_q     <= 1'b0;
      pv_q       <= 1'b0;
      locked_q   <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      lock_cnt_q <= lock_cnt_d;
      tick_q     <= tick_d;
      pv_q       <= pv_d;
      locked_q   <= locked_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.tick         = tick_q;
  assign bus.period       = period_q;
  assign bus.high_time    = high_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = tmo_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: directed square-wave stimulus with a period_valid scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_period_meter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(32)) bus ();

  clk_period_meter #(
    .CNT_W      (32),
    .EXP_PERIOD (100),
    .TOL        (2),
    .LOCK_N     (4),
    .TIMEOUT    (500)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned period;
    int unsigned high;
    int unsigned locked;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   tick_cnt = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic push(input int unsigned p, input int unsigned h, input int unsigned l);
    exp_t e;
    e.period = p;
    e.high   = h;
    e.locked = l;
    exp_q.push_back(e);
  endtask

  // Called on a negedge; rise-to-rise spacing is hi+lo clk cycles.
  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sig_in = 1'b1;
      repeat (hi) @(negedge clk);
      bus.sig_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  // Monitor: counts ticks and checks every period_valid against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.tick === 1'b1) tick_cnt++;
    if (bus.period_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pv_unexpected: period_valid with period=%0d, required no pulse", bus.period);
      end else begin
        e = exp_q.pop_front();
        chk("pv_period", bus.period, e.period);
        chk("pv_high_time", bus.high_time, e.high);
        chk("pv_locked", 32'(bus.locked), e.locked);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int snap;
    int to_idx;
    int tick_idx;
    int n_tk;
    int lk_before;
    int lk_at_to;

    rst        = 1'b0;
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_period", bus.period, 0);
    chk("rst_high_time", bus.high_time, 0);
    chk("rst_pv", 32'(bus.period_valid), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);

    rst = 1'b1;
    @(negedge clk);
    bus.en = 1'b1;
    repeat (3) @(negedge clk);

    // Divider-style 50/50: first rise silent, lock reported on the 5th rise.
    snap = tick_cnt;
    push(100, 50, 0); push(100, 50, 0); push(100, 50, 0);
    push(100, 50, 1); push(100, 50, 1);
    wave(50, 50, 6);
    chk("s1_ticks", tick_cnt - snap, 6);

    // Jump to 106 drops lock immediately; 101 relocks after 4 periods.
    push(100, 50, 1); push(106, 53, 0);
    push(101, 51, 0); push(101, 51, 0); push(101, 51, 0); push(101, 51, 1);
    wave(53, 53, 1);
    wave(51, 50, 5);

    // Last edge, then silence: tick latency and exact timeout placement.
    push(101, 51, 1);
    bus.sig_in = 1'b1;
    to_idx = -1; tick_idx = -1; n_tk = 0; lk_before = 0; lk_at_to = 1;
    for (int i = 1; i <= 600 && to_idx < 0; i++) begin
      @(negedge clk);
      if (i == 51) bus.sig_in = 1'b0;
      if (bus.tick === 1'b1) begin
        n_tk++;
        tick_idx = i;
      end
      if (i == 502) lk_before = int'(bus.locked);
      if (bus.timeout === 1'b1 && to_idx < 0) begin
        to_idx   = i;
        lk_at_to = int'(bus.locked);
      end
    end
    chk("tick_latency", tick_idx, 3);
    chk("tick_width", n_tk, 1);
    chk("timeout_cycle", to_idx, 503);
    chk("locked_before_timeout", lk_before, 1);
    chk("locked_at_timeout", lk_at_to, 0);
    repeat (20) @(negedge clk);
    chk("timeout_sticky", 32'(bus.timeout), 1);

    // Resume: timeout clears on the first rise, which reports nothing.
    bus.sig_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("timeout_before_tick", 32'(bus.timeout), 1);
    @(negedge clk);
    chk("timeout_cleared", 32'(bus.timeout), 0);
    chk("resume_tick", 32'(bus.tick), 1);
    repeat (47) @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (50) @(negedge clk);
    push(100, 50, 0); push(100, 50, 0); push(100, 50, 0); push(100, 50, 1);
    wave(50, 50, 4);

    // Disable mid-period: lock drops, results hold, no ticks while off.
    push(100, 50, 1);
    bus.sig_in = 1'b1;
    repeat (50) @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (20) @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_locked", 32'(bus.locked), 0);
    chk("dis_period_hold", bus.period, 100);
    chk("dis_high_hold", bus.high_time, 50);
    chk("dis_timeout", 32'(bus.timeout), 0);
    snap = tick_cnt;
    wave(50, 50, 1);
    chk("dis_no_tick", tick_cnt - snap, 0);

    // Re-enable: two rises needed before the first period_valid.
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    push(100, 50, 0); push(100, 50, 0);
    wave(50, 50, 3);

    // Async reset pulse between edges while measuring.
    push(100, 50, 0);
    bus.sig_in = 1'b1;
    repeat (20) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_period", bus.period, 0);
    chk("arst_high_time", bus.high_time, 0);
    chk("arst_tick", 32'(bus.tick), 0);
    chk("arst_pv", 32'(bus.period_valid), 0);
    chk("arst_locked", 32'(bus.locked), 0);
    chk("arst_timeout", 32'(bus.timeout), 0);
    @(negedge clk);
    bus.sig_in = 1'b0;
    #3 rst = 1'b1;
    repeat (5) @(negedge clk);
    snap = tick_cnt;
    push(100, 50, 0); push(100, 50, 0); push(100, 50, 0);
    push(100, 50, 1); push(100, 50, 1);
    wave(50, 50, 6);
    chk("recover_ticks", tick_cnt - snap, 6);

    // Sub-cycle glitch between edges is never sampled.
    snap = tick_cnt;
    @(negedge clk);
    #1 bus.sig_in = 1'b1;
    #2 bus.sig_in = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_no_tick", tick_cnt - snap, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
